// File: rtl/mu0_control_if.sv
// rtl/mu0_control_if.sv - MU0 control unit bus: datapath status in, datapath/memory controls out
// Signals:
//   F, N, Z, Mem_Ready           - opcode, Acc flags, memory completion (datapath -> control)
//   X_sel, Y_sel, Addr_sel, M    - ALU operand/address mux selects and ALU function
//   PC_En, IR_En, Acc_En         - register load enables
//   Rd, Wr                       - memory requests
//   Halted, Illegal, Instr_Count - run status and retired-instruction count
// Modports: master = control unit, slave = datapath/memory side.
interface mu0_control_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       F;
    logic             N;
    logic             Z;
    logic             Mem_Ready;
    logic             X_sel;
    logic             Y_sel;
    logic             Addr_sel;
    logic [1:0]       M;
    logic             PC_En;
    logic             IR_En;
    logic             Acc_En;
    logic             Rd;
    logic             Wr;
    logic             Halted;
    logic             Illegal;
    logic [CNT_W-1:0] Instr_Count;

    modport master (
        input  F, N, Z, Mem_Ready,
        output X_sel, Y_sel, Addr_sel, M, PC_En, IR_En, Acc_En, Rd, Wr,
               Halted, Illegal, Instr_Count
    );

    modport slave (
        output F, N, Z, Mem_Ready,
        input  X_sel, Y_sel, Addr_sel, M, PC_En, IR_En, Acc_En, Rd, Wr,
               Halted, Illegal, Instr_Count
    );
endinterface

// File: rtl/mu0_control.sv
// rtl/mu0_control.sv - MU0 fetch/execute control unit with memory ready stretching and retire counter
// Ports:
//   Clk   - system clock, rising edge
//   Reset - asynchronous active-high reset
//   bus   - mu0_control_if.master: F/N/Z/Mem_Ready in; mux selects, M, enables,
//           Rd/Wr, Halted, Illegal and Instr_Count out
module mu0_control #(
    parameter int CNT_W = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    mu0_control_if.master bus
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic       x_sel, y_sel, addr_sel;
    logic [1:0] m;
    logic       pc_en, ir_en, acc_en;
    logic       rd, wr, halted;
    logic       retire;
    logic       jump_taken;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        illegal_d  = illegal_q;
        count_d    = count_q;
        x_sel      = 1'b0;
        y_sel      = 1'b0;
        addr_sel   = 1'b0;
        m          = 2'b00;
        pc_en      = 1'b0;
        ir_en      = 1'b0;
        acc_en     = 1'b0;
        rd         = 1'b0;
        wr         = 1'b0;
        halted     = 1'b0;
        retire     = 1'b0;
        jump_taken = 1'b0;

        case (state_q)
            S_FETCH: begin
                // IR <= mem[PC] and PC <= PC+1 share the same completing cycle.
                rd       = 1'b1;
                addr_sel = 1'b0;
                x_sel    = 1'b1;
                m        = 2'b10;
                if (bus.Mem_Ready) begin
                    ir_en   = 1'b1;
                    pc_en   = 1'b1;
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                addr_sel = 1'b1;
                case (bus.F)
                    4'h0: begin
                        rd     = 1'b1;
                        m      = 2'b00;
                        acc_en = bus.Mem_Ready;
                        if (bus.Mem_Ready) state_d = S_FETCH;
                    end
                    4'h1: begin
                        wr = 1'b1;
                        if (bus.Mem_Ready) state_d = S_FETCH;
                    end
                    4'h2, 4'h3: begin
                        rd     = 1'b1;
                        x_sel  = 1'b0;
                        m      = (bus.F == 4'h3) ? 2'b11 : 2'b01;
                        acc_en = bus.Mem_Ready;
                        if (bus.Mem_Ready) state_d = S_FETCH;
                    end
                    4'h4, 4'h5, 4'h6: begin
                        // Jumps never touch memory, so Mem_Ready is irrelevant here.
                        jump_taken = (bus.F == 4'h4) ||
                                     (bus.F == 4'h5 && !bus.N) ||
                                     (bus.F == 4'h6 && !bus.Z);
                        if (jump_taken) begin
                            y_sel = 1'b1;
                            m     = 2'b00;
                            pc_en = 1'b1;
                        end
                        state_d = S_FETCH;
                    end
                    4'h7: begin
                        state_d = S_HALT;
                    end
                    default: begin
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
                    end
                endcase
                // STP retires on entry to HALT; undefined opcodes never retire.
                retire = (state_d == S_FETCH) || (bus.F == 4'h7);
            end

            S_HALT: begin
                halted = 1'b1;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (retire) count_d = count_q + CNT_W'(1);

        // Reset must silence the datapath immediately, not at the next edge.
        if (Reset) begin
            pc_en  = 1'b0;
            ir_en  = 1'b0;
            acc_en = 1'b0;
            rd     = 1'b0;
            wr     = 1'b0;
            halted = 1'b0;
        end
    end

    assign bus.X_sel       = x_sel;
    assign bus.Y_sel       = y_sel;
    assign bus.Addr_sel    = addr_sel;
    assign bus.M           = m;
    assign bus.PC_En       = pc_en;
    assign bus.IR_En       = ir_en;
    assign bus.Acc_En      = acc_en;
    assign bus.Rd          = rd;
    assign bus.Wr          = wr;
    assign bus.Halted      = halted;
    assign bus.Illegal     = illegal_q;
    assign bus.Instr_Count = count_q;

endmodule

// File: tb/tb_mu0_control.sv
// tb/tb_mu0_control.sv - self-checking bench for mu0_control
module tb_mu0_control;

    logic Clk;
    logic Reset;
    logic Reset3;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    mu0_control_if #(.CNT_W(16)) bus ();
    mu0_control_if #(.CNT_W(3))  bus3 ();

    mu0_control #(.CNT_W(16)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.master)
    );

    mu0_control #(.CNT_W(3)) dut3 (
        .Clk   (Clk),
        .Reset (Reset3),
        .bus   (bus3.master)
    );

    int checks = 0;
    int passed = 0;

    // Behavioural datapath around the DUT: memory, PC, IR, Acc and the MU0 ALU.
    logic [15:0] mem [0:4095];
    logic [15:0] pc, ir, acc;
    bit          dp_on;
    int          mr_pct;
    int          wait_cycles, wr_pulses, wr_bad, rw_both;

    // Instruction-level reference machine.
    logic [15:0] ref_mem [0:4095];
    logic [15:0] ref_pc, ref_acc;
    int          ref_ret, ref_exec;
    logic        ref_ill;

    // {X_sel, Y_sel, Addr_sel, M[1:0], PC_En, IR_En, Acc_En, Rd, Wr, Halted}
    function automatic logic [10:0] ctl();
        return {bus.X_sel, bus.Y_sel, bus.Addr_sel, bus.M, bus.PC_En, bus.IR_En,
                bus.Acc_En, bus.Rd, bus.Wr, bus.Halted};
    endfunction

    // Called at the falling edge; returns at the next falling edge.
    task automatic clk_step();
        logic [11:0] a;
        logic [15:0] x, y, q, rdata, wdata;
        logic [10:0] c;
        logic        mr;
        c     = ctl();
        mr    = bus.Mem_Ready;
        a     = bus.Addr_sel ? ir[11:0] : pc[11:0];
        rdata = mem[a];
        wdata = acc;
        x     = bus.X_sel ? pc : acc;
        y     = bus.Y_sel ? {4'h0, ir[11:0]} : rdata;
        case (bus.M)
            2'b00:   q = y;
            2'b01:   q = x + y;
            2'b10:   q = x + 16'd1;
            default: q = x - y;
        endcase
        if (c[2] && c[1]) rw_both++;
        if ((c[2] || c[1]) && !mr) wait_cycles++;
        if (c[1] && mr) begin
            wr_pulses++;
            if (!c[8]) wr_bad++;
        end
        @(posedge Clk);
        #1;
        if (dp_on) begin
            if (c[4]) ir = rdata;
            if (c[5]) pc = q;
            if (c[3]) acc = q;
            if (c[1] && mr) mem[a] = wdata;
            bus.F         = ir[15:12];
            bus.N         = acc[15];
            bus.Z         = (acc == 16'h0);
            bus.Mem_Ready = (int'($urandom_range(99)) < mr_pct);
        end
        @(negedge Clk);
    endtask

    task automatic isa_run();
        logic [15:0] p, ac, ins;
        p = 16'h0; ac = 16'h0;
        ref_ret = 0; ref_exec = 0; ref_ill = 1'b0;
        for (int n = 0; n < 500; n++) begin
            ins = ref_mem[p[11:0]];
            p   = p + 16'd1;
            ref_exec++;
            if (ins[15:12] >= 4'h7) begin
                ref_ill = ins[15];
                if (!ins[15]) ref_ret++;
                break;
            end
            case (ins[15:12])
                4'h0: ac = ref_mem[ins[11:0]];
                4'h1: ref_mem[ins[11:0]] = ac;
                4'h2: ac = ac + ref_mem[ins[11:0]];
                4'h3: ac = ac - ref_mem[ins[11:0]];
                4'h4: p = {4'h0, ins[11:0]};
                4'h5: if (!ac[15]) p = {4'h0, ins[11:0]};
                default: if (ac != 16'h0) p = {4'h0, ins[11:0]};
            endcase
            ref_ret++;
        end
        ref_pc  = p;
        ref_acc = ac;
    endtask

    task automatic test_reset();
        clk_step();
        clk_step();
        checks++;
        if ((ctl() & 11'h03F) !== 11'h000)
            $display("FAIL reset_outputs: got %b want enables/Rd/Wr/Halted all 0", ctl());
        else passed++;
        checks++;
        if (bus.Instr_Count !== 16'h0 || bus.Illegal !== 1'b0)
            $display("FAIL reset_regs: got count=%0h illegal=%b want 0/0", bus.Instr_Count, bus.Illegal);
        else passed++;
        Reset = 1'b0;
        bus.Mem_Ready = 1'b0;
        #1;
        checks++;
        if (ctl() !== 11'b10010000100)
            $display("FAIL reset_fetch: got %b want %b", ctl(), 11'b10010000100);
        else passed++;
    endtask

    task automatic test_fetch_stall();
        Reset = 1'b1; bus.F = 4'h0; bus.Mem_Ready = 1'b0;
        clk_step();
        Reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.Mem_Ready = (k == 3);
            #1;
            checks++;
            if ({bus.Rd, bus.Addr_sel, bus.IR_En, bus.PC_En} !== {1'b1, 1'b0, k == 3, k == 3})
                $display("FAIL fetch_stall_%0d: got Rd,Addr,IR,PC=%b%b%b%b want 10%b%b", k,
                         bus.Rd, bus.Addr_sel, bus.IR_En, bus.PC_En, k == 3, k == 3);
            else passed++;
            clk_step();
        end
        bus.Mem_Ready = 1'b0;
        #1;
        checks++;
        if (bus.Addr_sel !== 1'b1 || bus.Rd !== 1'b1)
            $display("FAIL fetch_stall_exec: got Addr_sel=%b Rd=%b want 1/1", bus.Addr_sel, bus.Rd);
        else passed++;
    endtask

    task automatic test_jumps();
        logic [3:0]  jf [5] = '{4'h5, 4'h5, 4'h6, 4'h6, 4'h4};
        logic        jn [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic        jz [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic        jt [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [10:0] exp, mask;
        Reset = 1'b1; bus.F = 4'h0;
        clk_step();
        Reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.Mem_Ready = 1'b1;
            #1;
            clk_step();
            bus.F = jf[i]; bus.N = jn[i]; bus.Z = jz[i]; bus.Mem_Ready = 1'b0;
            #1;
            exp  = jt[i] ? 11'b01100100000 : 11'b00100000000;
            mask = jt[i] ? 11'h7FF : 11'b00100111111;
            checks++;
            if ((ctl() & mask) !== exp)
                $display("FAIL jump_%0d_exec: got %b want %b (mask %b)", i, ctl(), exp, mask);
            else passed++;
            clk_step();
            checks++;
            if ({bus.Rd, bus.Addr_sel, bus.X_sel} !== 3'b101)
                $display("FAIL jump_%0d_single_cycle: got Rd,Addr,X=%b%b%b want 101", i,
                         bus.Rd, bus.Addr_sel, bus.X_sel);
            else passed++;
        end
        checks++;
        if (bus.Instr_Count !== 16'd5)
            $display("FAIL jump_count: got %0d want 5", bus.Instr_Count);
        else passed++;
    endtask

    task automatic test_illegal();
        bus.Mem_Ready = 1'b1;
        #1;
        clk_step();
        bus.F = 4'hA; bus.Mem_Ready = 1'($urandom_range(1));
        #1;
        checks++;
        if ((ctl() & 11'h03F) !== 11'h000 || bus.Illegal !== 1'b0)
            $display("FAIL illegal_exec: got %b illegal=%b want no enables, illegal 0", ctl(), bus.Illegal);
        else passed++;
        clk_step();
        checks++;
        if ({bus.Halted, bus.Illegal} !== 2'b11 || bus.Instr_Count !== 16'd5)
            $display("FAIL illegal_halt: got halted=%b illegal=%b count=%0d want 1/1/5",
                     bus.Halted, bus.Illegal, bus.Instr_Count);
        else passed++;
        for (int k = 0; k < 10; k++) begin
            bus.F = 4'($urandom_range(15)); bus.N = 1'($urandom_range(1));
            bus.Z = 1'($urandom_range(1)); bus.Mem_Ready = 1'($urandom_range(1));
            #1;
            checks++;
            if ({ctl() & 11'h03F, bus.Illegal} !== {11'h001, 1'b1})
                $display("FAIL illegal_hold_%0d: got %b illegal=%b want %b illegal=1", k,
                         ctl(), bus.Illegal, 11'h001);
            else passed++;
            clk_step();
        end
    endtask

    task automatic test_reset_mid_exec();
        Reset = 1'b1;
        #1;
        checks++;
        if (bus.Illegal !== 1'b0 || bus.Halted !== 1'b0)
            $display("FAIL async_clear: got illegal=%b halted=%b want 0/0", bus.Illegal, bus.Halted);
        else passed++;
        clk_step();
        Reset = 1'b0; bus.F = 4'h4; bus.Mem_Ready = 1'b1;
        #1;
        clk_step();
        clk_step();
        clk_step();
        bus.F = 4'h3; bus.Mem_Ready = 1'b0;
        #1;
        checks++;
        if ({bus.Rd, bus.X_sel, bus.M, bus.Acc_En} !== 5'b10110)
            $display("FAIL sub_exec: got Rd,X,M,AccEn=%b want 10110", {bus.Rd, bus.X_sel, bus.M, bus.Acc_En});
        else passed++;
        clk_step();
        checks++;
        if ({bus.Rd, bus.Addr_sel, bus.Acc_En} !== 3'b110 || bus.Instr_Count !== 16'd1)
            $display("FAIL sub_stall: got Rd,Addr,AccEn=%b count=%0d want 110/1",
                     {bus.Rd, bus.Addr_sel, bus.Acc_En}, bus.Instr_Count);
        else passed++;
        bus.Mem_Ready = 1'b1;
        #1;
        checks++;
        if (bus.Acc_En !== 1'b1)
            $display("FAIL sub_ready: got Acc_En=%b want 1", bus.Acc_En);
        else passed++;
        Reset = 1'b1;
        #1;
        checks++;
        if ({bus.Acc_En, bus.Rd} !== 2'b00 || bus.Instr_Count !== 16'd0)
            $display("FAIL reset_async: got AccEn,Rd=%b%b count=%0d want 00/0",
                     bus.Acc_En, bus.Rd, bus.Instr_Count);
        else passed++;
        clk_step();
        Reset = 1'b0; bus.Mem_Ready = 1'b0;
        #1;
        checks++;
        if ({bus.Rd, bus.Addr_sel, bus.Halted, bus.Illegal} !== 4'b1000 || bus.Instr_Count !== 16'd0)
            $display("FAIL reset_release: got Rd,Addr,Halted,Illegal=%b count=%0d want 1000/0",
                     {bus.Rd, bus.Addr_sel, bus.Halted, bus.Illegal}, bus.Instr_Count);
        else passed++;
    endtask

    task automatic dp_start(input int mr_p);
        dp_on = 1'b1; mr_pct = mr_p;
        pc = 16'h0; ir = 16'h0; acc = 16'h0;
        bus.F = 4'h0; bus.N = 1'b0; bus.Z = 1'b1; bus.Mem_Ready = (mr_p >= 100);
        Reset = 1'b1;
        clk_step();
        clk_step();
        Reset = 1'b0;
        wait_cycles = 0; wr_pulses = 0; wr_bad = 0;
        #1;
    endtask

    task automatic test_program();
        logic [1:0] exp_m [8] = '{2'b10, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00, 2'b10, 2'b00};
        bit         care  [8] = '{1, 1, 1, 1, 1, 0, 1, 0};
        int         early;
        mem[0] = 16'h0010; mem[1] = 16'h2011; mem[2] = 16'h1012; mem[3] = 16'h7000;
        mem[16'h10] = 16'h0005; mem[16'h11] = 16'h0003; mem[16'h12] = 16'h0000;
        dp_start(100);
        early = 0;
        for (int k = 0; k < 8; k++) begin
            if (bus.Halted) early++;
            if (care[k]) begin
                checks++;
                if (bus.M !== exp_m[k])
                    $display("FAIL prog_m_%0d: got %b want %b", k, bus.M, exp_m[k]);
                else passed++;
            end
            clk_step();
        end
        checks++;
        if (bus.Halted !== 1'b1 || early != 0)
            $display("FAIL prog_cycles: got halted=%b early=%0d want halted after exactly 8", bus.Halted, early);
        else passed++;
        checks++;
        if (wr_pulses != 1 || wr_bad != 0)
            $display("FAIL prog_wr: got pulses=%0d bad_addr=%0d want 1/0", wr_pulses, wr_bad);
        else passed++;
        checks++;
        if (bus.Instr_Count !== 16'd4 || acc !== 16'd8 || mem[16'h12] !== 16'd8)
            $display("FAIL prog_result: got count=%0d acc=%0h mem12=%0h want 4/8/8",
                     bus.Instr_Count, acc, mem[16'h12]);
        else passed++;
    endtask

    task automatic test_random_programs();
        int          L, cyc, diffs;
        logic [3:0]  op;
        for (int r = 0; r < 6; r++) begin
            L = 8 + int'($urandom_range(8));
            for (int i = 0; i < L - 1; i++) begin
                op = 4'($urandom_range(6));
                if (op <= 4'h3) mem[i] = {op, 12'h100 + 12'($urandom_range(15))};
                else            mem[i] = {op, 12'($urandom_range(L - 1, i + 1))};
            end
            if ($urandom_range(1) == 0) mem[L - 1] = 16'h7000;
            else mem[L - 1] = {4'($urandom_range(15, 8)), 12'($urandom_range(4095))};
            for (int j = 0; j < 16; j++)
                mem[16'h100 + j] = ($urandom_range(3) == 0) ? 16'h0 : 16'($urandom);
            for (int j = 0; j < 4096; j++) ref_mem[j] = mem[j];
            isa_run();
            dp_start((r % 2 == 0) ? 100 : 55);
            cyc = 0;
            while (!bus.Halted && cyc < 3000) begin
                clk_step();
                cyc++;
            end
            checks++;
            if (bus.Halted !== 1'b1 || cyc != 2 * ref_exec + wait_cycles)
                $display("FAIL rand_%0d_cycles: got %0d halted=%b want %0d", r, cyc, bus.Halted,
                         2 * ref_exec + wait_cycles);
            else passed++;
            checks++;
            if (acc !== ref_acc || pc !== ref_pc)
                $display("FAIL rand_%0d_regs: got acc=%0h pc=%0h want %0h/%0h", r, acc, pc, ref_acc, ref_pc);
            else passed++;
            checks++;
            if (bus.Instr_Count !== 16'(ref_ret) || bus.Illegal !== ref_ill)
                $display("FAIL rand_%0d_status: got count=%0d illegal=%b want %0d/%b", r,
                         bus.Instr_Count, bus.Illegal, ref_ret, ref_ill);
            else passed++;
            diffs = 0;
            for (int j = 16'h100; j < 16'h110; j++) if (mem[j] !== ref_mem[j]) diffs++;
            checks++;
            if (diffs != 0)
                $display("FAIL rand_%0d_mem: got %0d differing words want 0", r, diffs);
            else passed++;
        end
        dp_on = 1'b0;
    endtask

    task automatic test_wrap();
        bus3.F = 4'h4; bus3.N = 1'b0; bus3.Z = 1'b0; bus3.Mem_Ready = 1'b1;
        Reset3 = 1'b0;
        #1;
        checks++;
        if (bus3.Instr_Count !== 3'd0)
            $display("FAIL wrap_start: got %0d want 0", bus3.Instr_Count);
        else passed++;
        for (int r = 1; r <= 9; r++) begin
            clk_step();
            clk_step();
            checks++;
            if (bus3.Instr_Count !== 3'(r % 8) || bus3.Halted !== 1'b0)
                $display("FAIL wrap_%0d: got %0d halted=%b want %0d", r, bus3.Instr_Count,
                         bus3.Halted, r % 8);
            else passed++;
        end
    endtask

    initial begin
        Reset = 1'b1; Reset3 = 1'b1;
        dp_on = 1'b0; mr_pct = 100;
        pc = 16'h0; ir = 16'h0; acc = 16'h0;
        wait_cycles = 0; wr_pulses = 0; wr_bad = 0; rw_both = 0;
        for (int j = 0; j < 4096; j++) mem[j] = 16'h0;
        bus.F = 4'h0; bus.N = 1'b0; bus.Z = 1'b0; bus.Mem_Ready = 1'b1;
        bus3.F = 4'h4; bus3.N = 1'b0; bus3.Z = 1'b0; bus3.Mem_Ready = 1'b1;

        test_reset();
        test_fetch_stall();
        test_jumps();
        test_illegal();
        test_reset_mid_exec();
        test_program();
        test_random_programs();
        test_wrap();

        checks++;
        if (rw_both != 0)
            $display("FAIL rd_wr_exclusive: got %0d cycles with both want 0", rw_both);
        else passed++;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mu0_control.md
Name: mu0_control

Overview:
- Control unit for the MU0 processor.
- Sequences the datapath: the PC, IR and Acc registers, the X/Y/address muxes, and the MU0 ALU function select M.
- Runs a fetch/execute state machine and decodes the 4-bit opcode F.
- Stretches memory accesses with a ready handshake, and counts retired instructions.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- Clk  input  1  system clock; rising edge.
- Reset  input  1  asynchronous, active-high reset.
- F  input  4  opcode, IR[15:12].
- N  input  1  Acc negative flag (Acc[15]).
- Z  input  1  Acc zero flag.
- Mem_Ready  input  1  memory completes the current Rd/Wr this cycle.
- X_sel  output  1  ALU X operand: 0 = Acc, 1 = PC.
- Y_sel  output  1  ALU Y operand: 0 = memory data, 1 = IR[11:0] zero-extended.
- Addr_sel  output  1  address bus: 0 = PC, 1 = IR[11:0].
- M  output  2  ALU function: 00 Q=Y, 01 Q=X+Y, 10 Q=X+1, 11 Q=X-Y.
- PC_En  output  1  PC load enable.
- IR_En  output  1  IR load enable.
- Acc_En  output  1  Acc load enable.
- Rd  output  1  memory read request.
- Wr  output  1  memory write request (data = Acc).
- Halted  output  1  processor stopped.
- Illegal  output  1  stopped on an undefined opcode.
- Instr_Count  output  CNT_W  instructions retired since reset.

Behaviour:
- States: FETCH, EXEC, HALT. Encoding is free; the state register is the only sequential decision.
- Reset (async, any time, including mid-access):
  - State goes to FETCH; Illegal=0; Instr_Count=0.
  - While Reset is high, all enables, Rd and Wr are 0, and Halted=0.
- All outputs except Instr_Count and Illegal are combinational from state, F, N, Z and Mem_Ready. Unlisted outputs default to 0.
- FETCH:
  - Addr_sel=0, Rd=1, X_sel=1, M=10.
  - If Mem_Ready=1: IR_En=1, PC_En=1, next state EXEC.
  - Else: hold FETCH with enables 0, and Rd/Addr_sel held stable.
- EXEC drives Addr_sel=1 for every opcode. Per opcode:
  - 0 LDA: Rd=1, Y_sel=0, M=00. Acc_En=Mem_Ready.
  - 1 STA: Wr=1. No register enables.
  - 2 ADD: Rd=1, X_sel=0, Y_sel=0, M=01. Acc_En=Mem_Ready.
  - 3 SUB: as ADD but M=11.
  - 4 JMP: Y_sel=1, M=00, PC_En=1. No memory access.
  - 5 JGE: as JMP if N=0; otherwise no enables.
  - 6 JNE: as JMP if Z=0; otherwise no enables.
  - 7 STP: no enables; next state HALT.
  - 8-F: no enables; next state HALT; Illegal set to 1 on the transition.
- EXEC exits:
  - Memory opcodes (0-3) stay in EXEC until Mem_Ready=1, then go to FETCH.
  - Opcodes 4-6 complete in one cycle and ignore Mem_Ready.
- Retirement: an instruction retires on the EXEC-exit edge to FETCH, or on entry to HALT for STP. Illegal opcodes do not retire.
- Instr_Count increments by 1 per retirement and wraps modulo 2^CNT_W.
- HALT:
  - Halted=1; all enables, Rd and Wr are 0.
  - Stays in HALT until Reset; Illegal holds its value.
- Rd and Wr are never both 1. Request signals stay stable while Mem_Ready=0.
- Minimum time per instruction: 2 cycles with Mem_Ready tied to 1.
- Each Mem_Ready wait cycle adds one cycle to the access it stalls.

Test Plan:
- Mem_Ready=1, program LDA 0x010 (data 0x0005), ADD 0x011 (data 0x0003), STA 0x012, STP:
  - Required: 8 cycles to Halted=1.
  - Required: Wr pulses once with Addr_sel=1; Instr_Count=4.
  - Required: M sequence 10,00,10,01,10,xx,10,xx, where xx = don't care during STA/STP.
- FETCH with Mem_Ready low for 3 cycles, then high:
  - Required: Rd=1 and Addr_sel=0 held for all 4 cycles.
  - Required: IR_En and PC_En both 1 only in the 4th cycle.
- Jumps:
  - JGE with N=1: no PC_En in EXEC.
  - JGE with N=0: PC_En=1, Y_sel=1, M=00.
  - JNE with Z=1: no PC_En; with Z=0: PC_En=1.
  - Each is a single EXEC cycle even with Mem_Ready=0.
- Opcode 0xA in EXEC:
  - Required: next cycle Halted=1, Illegal=1, Instr_Count unchanged.
  - Required: Rd/Wr/enables stay 0 for 10 further cycles.
- Reset asserted mid-EXEC of SUB with Mem_Ready=0:
  - Required: Acc_En=0 and Rd=0 immediately (asynchronous).
  - Required: after release, FETCH with Rd=1; Instr_Count=0, Illegal=0.
- CNT_W=3, nine JMP instructions with Mem_Ready=1:
  - Required: Instr_Count reads 1 after the ninth retirement (wrap 7→0→1).
